// File: rtl/sobel_edge_detector.sv
// Sobel edge detector: scans a grayscale frame and writes |Gx|+|Gy|>>2 as a YCrCb edge map, zero border.
// Latency READ_LATENCY+5 cycles per interior column; the frame runs free once started and the read/write ports never stall.
module sobel_edge_detector #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [18:0] read_addr,
    input  logic [35:0] read_data,
    output logic [18:0] write_addr,
    output logic [35:0] write_data,
    output logic        write_enable
);
    typedef enum logic [2:0] {
        IDLE, BORDER_ROW, FETCH, CALC, WRITE, EDGE, FINISH
    } state_t;

    localparam logic [9:0]  XLAST = 10'(WIDTH - 1);
    localparam logic [8:0]  YLAST = 9'(HEIGHT - 1);
    localparam logic [2:0]  KCAP0 = 3'(READ_LATENCY);
    localparam logic [2:0]  KCAP1 = 3'(READ_LATENCY + 1);
    localparam logic [2:0]  KLAST = 3'(READ_LATENCY + 2);
    localparam logic [35:0] BLANK = {6'b0, 10'd0, 10'd512, 10'd512};

    state_t      state_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic [2:0]  k_q;
    logic        busy_q, done_q, we_q;
    logic [18:0] raddr_q, waddr_q;
    logic [35:0] wdata_q;
    logic [9:0]  win_q [3][3];
    logic [9:0]  ncol_q [2];

    logic [9:0]  pix_y;
    logic        unused_bits;
    assign pix_y       = read_data[29:20];
    assign unused_bits = ^{read_data[35:30], read_data[19:0]};

    // win_q[column][row]: column 0/1/2 = L/M/R, row 0/1/2 = T/C/B
    logic [12:0]        sum_l, sum_r, sum_t, sum_b;
    logic signed [12:0] gx, gy;
    logic [12:0]        ax, ay;
    logic [13:0]        mag;
    logic [9:0]         edge_val;

    always_comb begin
        sum_l    = 13'(win_q[0][0]) + 13'({win_q[0][1], 1'b0}) + 13'(win_q[0][2]);
        sum_r    = 13'(win_q[2][0]) + 13'({win_q[2][1], 1'b0}) + 13'(win_q[2][2]);
        sum_t    = 13'(win_q[0][0]) + 13'({win_q[1][0], 1'b0}) + 13'(win_q[2][0]);
        sum_b    = 13'(win_q[0][2]) + 13'({win_q[1][2], 1'b0}) + 13'(win_q[2][2]);
        gx       = sum_r - sum_l;
        gy       = sum_b - sum_t;
        ax       = gx[12] ? $unsigned(-gx) : $unsigned(gx);
        ay       = gy[12] ? $unsigned(-gy) : $unsigned(gy);
        mag      = {1'b0, ax} + {1'b0, ay};
        edge_val = (mag[13:12] != 2'b00) ? 10'd1023 : mag[11:2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    win_q[c][r] <= '0;
            ncol_q[0] <= '0;
            ncol_q[1] <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE, FINISH: begin
                    if (start) begin
                        state_q <= BORDER_ROW;
                        x_q     <= '0;
                        y_q     <= '0;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        waddr_q <= '0;
                        wdata_q <= BLANK;
                        for (int c = 0; c < 3; c++)
                            for (int r = 0; r < 3; r++)
                                win_q[c][r] <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BORDER_ROW: begin
                    if (x_q != XLAST) begin
                        x_q     <= x_q + 10'd1;
                        we_q    <= 1'b1;
                        waddr_q <= {y_q, x_q + 10'd1};
                        wdata_q <= BLANK;
                    end else if (y_q == 9'd0) begin
                        state_q <= FETCH;
                        x_q     <= '0;
                        y_q     <= 9'd1;
                        k_q     <= '0;
                        raddr_q <= '0;
                    end else begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    // read_addr is loaded one cycle ahead so it is visible during k=0,1,2
                    if (k_q == 3'd0) raddr_q <= {y_q, x_q};
                    if (k_q == 3'd1) raddr_q <= {y_q + 9'd1, x_q};
                    if (k_q == KCAP0) ncol_q[0] <= pix_y;
                    if (k_q == KCAP1) ncol_q[1] <= pix_y;
                    if (k_q == KLAST) begin
                        win_q[0]    <= win_q[1];
                        win_q[1]    <= win_q[2];
                        win_q[2][0] <= ncol_q[0];
                        win_q[2][1] <= ncol_q[1];
                        win_q[2][2] <= pix_y;
                        k_q         <= '0;
                        state_q     <= CALC;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                CALC: begin
                    state_q <= WRITE;
                    if (x_q != 10'd0) begin
                        we_q    <= 1'b1;
                        waddr_q <= {y_q, x_q - 10'd1};
                        wdata_q <= {6'b0, (x_q == 10'd1) ? 10'd0 : edge_val, 10'd512, 10'd512};
                    end
                end
                WRITE: begin
                    if (x_q != XLAST) begin
                        x_q     <= x_q + 10'd1;
                        state_q <= FETCH;
                        raddr_q <= {y_q - 9'd1, x_q + 10'd1};
                    end else begin
                        state_q <= EDGE;
                        we_q    <= 1'b1;
                        waddr_q <= {y_q, XLAST};
                        wdata_q <= BLANK;
                    end
                end
                EDGE: begin
                    y_q <= y_q + 9'd1;
                    x_q <= '0;
                    if (y_q + 9'd1 != YLAST) begin
                        state_q <= FETCH;
                        k_q     <= '0;
                        raddr_q <= {y_q, 10'd0};
                    end else begin
                        state_q <= BORDER_ROW;
                        we_q    <= 1'b1;
                        waddr_q <= {y_q + 9'd1, 10'd0};
                        wdata_q <= BLANK;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign read_addr    = raddr_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign write_enable = we_q;
endmodule

// File: tb/tb_sobel_edge_detector.sv
// Drives three detectors (read latency 1, 2, 3) with the same frames and checks every write against a Sobel model.
module tb_sobel_edge_detector;
    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start;
    logic        busy [3], done [3], we [3];
    logic [18:0] ra [3], wa [3];
    logic [35:0] rd [3], wd [3];

    sobel_edge_detector #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
        .read_addr(ra[0]), .read_data(rd[0]), .write_addr(wa[0]), .write_data(wd[0]),
        .write_enable(we[0]));
    sobel_edge_detector #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .reset(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
        .read_addr(ra[1]), .read_data(rd[1]), .write_addr(wa[1]), .write_data(wd[1]),
        .write_enable(we[1]));
    sobel_edge_detector #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(3)) u_l3 (
        .clk(clk), .reset(rst_n), .start(start), .busy(busy[2]), .done(done[2]),
        .read_addr(ra[2]), .read_data(rd[2]), .write_addr(wa[2]), .write_data(wd[2]),
        .write_enable(we[2]));

    int src [H][W];
    int written [3][H][W];
    int dst [3][H][W];
    int busy_cnt [3], done_cnt [3], wcnt [3];
    int n_pass = 0, n_total = 0;

    // Source memory: address seen in cycle n returns data in cycle n+latency
    logic [18:0] pipe [3][3];
    logic [19:0] junk;

    function automatic logic [9:0] pix_at(logic [18:0] a);
        int x, y;
        x = int'(a[9:0]);
        y = int'(a[18:10]);
        if (x < W && y < H) return 10'(src[y][x]);
        return 10'd0;
    endfunction

    always @(posedge clk) begin
        junk <= 20'($urandom);
        for (int i = 0; i < 3; i++) begin
            pipe[i][0] <= ra[i];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) rd[i] = {junk[5:0], pix_at(pipe[i][i]), junk};
    end

    function automatic int exp_edge(int x, int y);
        int k [3][3];
        int gx, gy, m;
        k = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        gx = 0;
        gy = 0;
        if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                gx += k[dy + 1][dx + 1] * src[y + dy][x + dx];
                gy += k[dx + 1][dy + 1] * src[y + dy][x + dx];
            end
        m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        m = m / 4;
        return (m > 1023) ? 1023 : m;
    endfunction

    function automatic int frame_len(int lat);
        return 2 * W + (H - 2) * (W * (lat + 5) + 1);
    endfunction

    task automatic check(string name, int got, int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    endtask

    task automatic load(int kind);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (kind)
                    0: src[y][x] = 300;
                    1: src[y][x] = (x <= 3) ? 0 : 1023;
                    2: src[y][x] = (x == 3 && y == 3) ? 1023 : 0;
                    3: src[y][x] = ((x == 4 && y >= 2 && y <= 4) || (y == 4 && (x == 2 || x == 3))) ? 1023 : 0;
                    4: src[y][x] = 10 * x;
                    default: src[y][x] = int'($urandom_range(0, 1023));
                endcase
    endtask

    task automatic clear_counters();
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
            wcnt[i] = 0;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    written[i][y][x] = 0;
                    dst[i][y][x] = -1;
                end
        end
    endtask

    task automatic sample();
        int x, y;
        for (int i = 0; i < 3; i++) begin
            if (busy[i]) busy_cnt[i]++;
            if (done[i]) begin
                done_cnt[i]++;
                check($sformatf("done_with_write_L%0d", i + 1), int'(we[i]), 0);
            end
            if (we[i]) begin
                wcnt[i]++;
                x = int'(wa[i][9:0]);
                y = int'(wa[i][18:10]);
                check($sformatf("addr_range_L%0d", i + 1), int'(x < W && y < H), 1);
                check($sformatf("word_format_L%0d", i + 1),
                      int'(wd[i][35:30] == 6'd0 && wd[i][19:0] == {10'd512, 10'd512}), 1);
                if (x < W && y < H) begin
                    check($sformatf("write_once_L%0d_x%0d_y%0d", i + 1, x, y), written[i][y][x], 0);
                    written[i][y][x] = 1;
                    dst[i][y][x] = int'(wd[i][29:20]);
                    check($sformatf("edge_L%0d_x%0d_y%0d", i + 1, x, y), int'(wd[i][29:20]), exp_edge(x, y));
                end
            end
        end
    endtask

    task automatic check_idle_outputs(string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_busy_L%0d", tag, i + 1), int'(busy[i]), 0);
            check($sformatf("%s_done_L%0d", tag, i + 1), int'(done[i]), 0);
            check($sformatf("%s_we_L%0d", tag, i + 1), int'(we[i]), 0);
            check($sformatf("%s_raddr_L%0d", tag, i + 1), int'(ra[i]), 0);
            check($sformatf("%s_waddr_L%0d", tag, i + 1), int'(wa[i]), 0);
            check($sformatf("%s_wdata_L%0d", tag, i + 1), int'(wd[i] != 36'd0), 0);
        end
    endtask

    // chain_in: caller's last negedge showed the final done, so start is driven in that done cycle
    task automatic run_frame(string tag, bit mid_start, bit chain_in, bit chain_out);
        int cyc;
        clear_counters();
        if (!chain_in) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sample();
        cyc = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0 || done_cnt[2] == 0) && cyc < 400) begin
            @(negedge clk);
            start = (mid_start && cyc == 90);
            sample();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_timeout"}, int'(cyc < 400), 1);
        if (!chain_out) repeat (4) begin
            @(negedge clk);
            sample();
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_writes_L%0d", tag, i + 1), wcnt[i], W * H);
            check($sformatf("%s_done_count_L%0d", tag, i + 1), done_cnt[i], 1);
            check($sformatf("%s_busy_len_L%0d", tag, i + 1), busy_cnt[i], frame_len(i + 1));
        end
    endtask

    initial begin
        int w_at_reset [3];
        rst_n = 1'b1;
        start = 1'b0;
        load(0);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame("flat", 1'b0, 1'b0, 1'b0);
        check("flat_busy_244", busy_cnt[1], 244);
        check("flat_edge_3_2", dst[1][2][3], 0);

        load(1);
        run_frame("vstep", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("vstep_x3y1_L%0d", i + 1), dst[i][1][3], 1023);
            check($sformatf("vstep_x4y4_L%0d", i + 1), dst[i][4][4], 1023);
            check($sformatf("vstep_x2y2_L%0d", i + 1), dst[i][2][2], 0);
            check($sformatf("vstep_x4y0_L%0d", i + 1), dst[i][0][4], 0);
        end

        load(2);
        check("model_single_2_2", exp_edge(2, 2), 511);
        run_frame("single", 1'b0, 1'b0, 1'b0);
        check("single_x2y2", dst[1][2][2], 511);
        check("single_x2y3", dst[1][3][2], 511);
        check("single_x3y2", dst[1][2][3], 511);
        check("single_x4y4", dst[1][4][4], 511);
        check("single_x3y3", dst[1][3][3], 0);
        check("single_x3y0", dst[1][0][3], 0);

        load(3);
        check("model_lshape_3_3", exp_edge(3, 3), 1023);
        run_frame("lshape", 1'b0, 1'b0, 1'b0);
        check("lshape_x3y3", dst[1][3][3], 1023);

        load(4);
        run_frame("ramp", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ramp_x4y2_L%0d", i + 1), dst[i][2][4], 20);
            check($sformatf("ramp_x1y4_L%0d", i + 1), dst[i][4][1], 20);
        end

        load(5);
        run_frame("rand_midstart", 1'b1, 1'b0, 1'b1);
        load(5);
        run_frame("rand_chained", 1'b0, 1'b1, 1'b0);

        load(0);
        clear_counters();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sample();
        repeat (100) begin
            @(negedge clk);
            sample();
        end
        rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        for (int i = 0; i < 3; i++) w_at_reset[i] = wcnt[i];
        repeat (5) begin
            @(negedge clk);
            sample();
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            sample();
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midreset_no_done_L%0d", i + 1), done_cnt[i], 0);
            check($sformatf("midreset_no_writes_L%0d", i + 1), wcnt[i], w_at_reset[i]);
        end

        run_frame("flat_again", 1'b0, 1'b0, 1'b0);
        check("flat_again_busy_244", busy_cnt[1], 244);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sobel_edge_detector.md
# sobel_edge_detector

Downstream of `gaussian_blurrer` in the Rectilinearizer pipeline. On `start` it scans the blurred grayscale frame in the source bank, computes the 3x3 Sobel gradient magnitude for every interior pixel, and writes a grayscale edge map to the destination bank. Output is in the same YCrCb word format the blurrer produces, so the corner finder consumes it unchanged. Reads and writes use separate ports, so the source bank is never overwritten.

## Interface
- `WIDTH`, 640, pixels per line (x is 10 bits).
- `HEIGHT`, 480, lines per frame (y is 9 bits).
- `READ_LATENCY`, 2, cycles from `read_addr` to valid `read_data` (1..3).
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  one-cycle pulse; begins a frame when idle.
- `busy`  out  1  high from the cycle after an accepted `start` through the final write.
- `done`  out  1  one-cycle pulse, the cycle after the final write.
- `read_addr`  out  19  source address {y[8:0], x[9:0]}.
- `read_data`  in  36  source word; Y is taken from [29:20].
- `write_addr`  out  19  destination address {y[8:0], x[9:0]}.
- `write_data`  out  36  {6'b0, edge[9:0], 10'd512, 10'd512}.
- `write_enable`  out  1  one-cycle write strobe.

## Operation
- States: IDLE, BORDER_ROW, FETCH, CALC, WRITE, EDGE, FINISH.
- IDLE: `start` loads x=0, y=0, clears the window, and moves to BORDER_ROW. `start` in any other state is ignored.
- BORDER_ROW applies to y=0 and y=HEIGHT-1.
  - One zero write per cycle for x=0..WIDTH-1; no reads.
  - At end of row: y=0 goes to FETCH with column c=0; y=HEIGHT-1 goes to FINISH.
- FETCH handles column c of interior row y.
  - Counter k runs 0..READ_LATENCY+2.
  - Addresses {y-1,c}, {y,c}, {y+1,c} are issued at k=0,1,2.
  - `read_data[29:20]` is captured at k=READ_LATENCY, +1, +2 into the new right column.
  - At the final k, the 3x3 window of 10-bit registers shifts left by one column.
- CALC, one cycle, with window columns L, M, R and rows T, C, B:
  - Gx = (RT + 2RC + RB) - (LT + 2LC + LB).
  - Gy = (LB + 2MB + RB) - (LT + 2MT + RT).
  - Gx and Gy are signed 13-bit.
  - mag = |Gx| + |Gy|, unsigned 14-bit, max 8184.
  - edge = mag >> 2, saturated to 1023.
- WRITE: for c>=1, writes pixel x=c-1. The value is 0 when c-1=0, otherwise the computed edge. For c=0 there is no write and the cycle is a bubble.
  - If c<WIDTH-1: c++ and return to FETCH.
  - Otherwise go to EDGE.
- EDGE: writes 0 to x=WIDTH-1, then y++.
  - Next state is FETCH with c=0 if the new y < HEIGHT-1, else BORDER_ROW.
- FINISH: `busy` drops, `done` pulses for one cycle, then IDLE.
- Every destination pixel is written exactly once per frame: WIDTH*HEIGHT writes in total.

## Timing
- Reset values: `busy`=0, `done`=0, `write_enable`=0, `read_addr`=0, `write_addr`=0, `write_data`=0, state IDLE.
- Reset asserted mid-frame aborts immediately. No further writes occur, and no `done` is issued.
- `write_addr`, `write_data`, and `write_enable` are registered and change together. Outside write cycles `write_enable`=0, and the other two hold their last values.
- `read_addr` holds its last value outside FETCH issue cycles.
- Cycles per interior column: READ_LATENCY+5. Per interior row: WIDTH*(READ_LATENCY+5)+1. Per border row: WIDTH.
- Frame length in `busy` cycles: 2*WIDTH + (HEIGHT-2)*(WIDTH*(READ_LATENCY+5)+1).
- `done` is never asserted in the same cycle as `write_enable`. Assertion of `start` on the same cycle as `done` is accepted.

## Test plan
- Flat frame, all Y=300, WIDTH=8, HEIGHT=6, READ_LATENCY=2: exactly 48 writes, all edge=0; `done` once; `busy` high for exactly 244 cycles.
- Vertical step, Y=0 for x<=3 and 1023 for x>=4: edge=1023 at x=3,4 for y=1..4; all other pixels 0.
- Single bright pixel Y=1023 at (3,3): edge=511 at (2,2), (2,3), (3,2), (4,4); edge=0 at (3,3) and at every border pixel.
- L-shape Y=1023 at (4,2), (4,3), (4,4), (2,4), (3,4): at (3,3) mag=6138, which saturates to edge=1023; every write_data[9:0]=512 and [35:30]=0.
- Assert `start` mid-frame, then pull `reset` low mid-row: the extra `start` does not disturb the write sequence; after reset, outputs are 0 and `done` never pulses; a fresh `start` reproduces the flat-frame result.
- Sweep READ_LATENCY over 1, 2, and 3 with a ramp Y=10*x: interior edge=20 at every latency; frame length matches the formula.
